// File: rtl/fadd32_seq_if.sv
// Operand/result handshake bundle for the sequential binary32 adder.
// The producer/consumer side uses master; the adder uses slave.
interface fadd32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        busy;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, res, busy
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, res, busy
    );
endinterface

// File: rtl/fadd32_seq.sv
// Multi-cycle IEEE-754 binary32 add/subtract sequencer.
// Bit-serial align and normalize, round-to-nearest-even.
module fadd32_seq (
    input  logic       clk,
    input  logic       rst,
    fadd32_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_a, r_b, r_res;
    logic [31:0] w_a_n, w_b_n, w_res_n;
    logic [26:0] r_m1, r_m2, w_m1_n, w_m2_n;
    logic [9:0]  r_exp, w_exp_n;
    logic [4:0]  r_d, w_d_n;
    logic        r_s1, r_s2, r_sign, r_spec;
    logic        w_s1_n, w_s2_n, w_sign_n, w_spec_n;

    // Unpack: exponent compare and operand swap
    logic [7:0]  w_ea, w_eb, w_xa, w_xb;
    logic [8:0]  w_diff;
    logic [4:0]  w_d;
    logic [26:0] w_ma, w_mb;
    logic        w_infa, w_infb, w_nan, w_swap;

    assign w_ea   = r_a[30:23];
    assign w_eb   = r_b[30:23];
    assign w_xa   = (w_ea == 8'd0) ? 8'd1 : w_ea;
    assign w_xb   = (w_eb == 8'd0) ? 8'd1 : w_eb;
    assign w_ma   = {(w_ea != 8'd0), r_a[22:0], 3'b000};
    assign w_mb   = {(w_eb != 8'd0), r_b[22:0], 3'b000};
    assign w_infa = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_infb = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_nan  = ((w_ea == 8'hFF) && (r_a[22:0] != 23'd0))
                 || ((w_eb == 8'hFF) && (r_b[22:0] != 23'd0))
                 || (w_infa && w_infb && (r_a[31] != r_b[31]));
    assign w_swap = (w_xb > w_xa);
    assign w_diff = w_swap ? ({1'b0, w_xb} - {1'b0, w_xa})
                           : ({1'b0, w_xa} - {1'b0, w_xb});
    assign w_d    = (w_diff > 9'd26) ? 5'd26 : w_diff[4:0];

    // Magnitude add/subtract; sign follows the larger magnitude
    logic [27:0] w_sum;
    logic        w_sum_sign;

    always_comb begin
        w_sum      = {1'b0, r_m1} + {1'b0, r_m2};
        w_sum_sign = r_s1;
        if (r_s1 != r_s2) begin
            if (r_m1 >= r_m2) begin
                w_sum      = {1'b0, r_m1} - {1'b0, r_m2};
                w_sum_sign = r_s1;
            end else begin
                w_sum      = {1'b0, r_m2} - {1'b0, r_m1};
                w_sum_sign = r_s2;
            end
        end
    end

    // Round to nearest even on guard/round/sticky
    logic        w_rup;
    logic [24:0] w_mr;
    logic [23:0] w_mf;
    logic [9:0]  w_er;
    logic [31:0] w_rres;

    assign w_rup = r_m1[2] & (r_m1[1] | r_m1[0] | r_m1[3]);
    assign w_mr  = {1'b0, r_m1[26:3]} + {24'd0, w_rup};
    assign w_mf  = w_mr[24] ? w_mr[24:1] : w_mr[23:0];
    assign w_er  = r_exp + {9'd0, w_mr[24]};

    always_comb begin
        if (w_er >= 10'd255)
            w_rres = {r_sign, 8'hFF, 23'd0};
        else if (!w_mf[23])
            w_rres = {r_sign, 8'd0, w_mf[22:0]};
        else
            w_rres = {r_sign, w_er[7:0], w_mf[22:0]};
    end

    always_comb begin
        w_state_n = r_state;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_res_n   = r_res;
        w_m1_n    = r_m1;
        w_m2_n    = r_m2;
        w_exp_n   = r_exp;
        w_d_n     = r_d;
        w_s1_n    = r_s1;
        w_s2_n    = r_s2;
        w_sign_n  = r_sign;
        w_spec_n  = r_spec;
        unique case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_a_n     = bus.a;
                    w_b_n     = {bus.b[31] ^ bus.mode, bus.b[30:0]};
                    w_state_n = S_UNPACK;
                end
            end
            S_UNPACK: begin
                w_spec_n = 1'b1;
                // Specials borrow the ROUND slot so they finish in 2 cycles
                if (w_nan) begin
                    w_res_n   = 32'h7FC00000;
                    w_state_n = S_ROUND;
                end else if (w_infa) begin
                    w_res_n   = r_a;
                    w_state_n = S_ROUND;
                end else if (w_infb) begin
                    w_res_n   = r_b;
                    w_state_n = S_ROUND;
                end else begin
                    w_spec_n = 1'b0;
                    if (w_swap) begin
                        w_m1_n  = w_mb;
                        w_m2_n  = w_ma;
                        w_s1_n  = r_b[31];
                        w_s2_n  = r_a[31];
                        w_exp_n = {2'b00, w_xb};
                    end else begin
                        w_m1_n  = w_ma;
                        w_m2_n  = w_mb;
                        w_s1_n  = r_a[31];
                        w_s2_n  = r_b[31];
                        w_exp_n = {2'b00, w_xa};
                    end
                    w_d_n     = w_d;
                    w_state_n = (w_d != 5'd0) ? S_ALIGN : S_ADD;
                end
            end
            S_ALIGN: begin
                w_m2_n = {1'b0, r_m2[26:2], r_m2[1] | r_m2[0]};
                w_d_n  = r_d - 5'd1;
                if (r_d == 5'd1)
                    w_state_n = S_ADD;
            end
            S_ADD: begin
                w_sign_n  = (w_sum == 28'd0) ? (r_s1 & r_s2) : w_sum_sign;
                w_state_n = S_ROUND;
                if (w_sum[27]) begin
                    w_m1_n  = {w_sum[27:2], |w_sum[1:0]};
                    w_exp_n = r_exp + 10'd1;
                end else begin
                    w_m1_n = w_sum[26:0];
                    if (w_sum != 28'd0 && !w_sum[26] && r_exp > 10'd1)
                        w_state_n = S_NORM;
                end
            end
            S_NORM: begin
                w_m1_n  = {r_m1[25:0], 1'b0};
                w_exp_n = r_exp - 10'd1;
                if (r_m1[25] || r_exp == 10'd2)
                    w_state_n = S_ROUND;
            end
            S_ROUND: begin
                w_res_n   = r_spec ? r_res : w_rres;
                w_state_n = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready)
                    w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_m1    <= '0;
            r_m2    <= '0;
            r_exp   <= '0;
            r_d     <= '0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_sign  <= 1'b0;
            r_spec  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_res   <= w_res_n;
            r_m1    <= w_m1_n;
            r_m2    <= w_m2_n;
            r_exp   <= w_exp_n;
            r_d     <= w_d_n;
            r_s1    <= w_s1_n;
            r_s2    <= w_s2_n;
            r_sign  <= w_sign_n;
            r_spec  <= w_spec_n;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.res       = r_res;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_fadd32_seq.sv
// Self-checking bench for fadd32_seq: directed vectors, handshake
// corners and random operands against an exact-arithmetic model.
module tb_fadd32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    fadd32_seq_if bus ();

    fadd32_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        m;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Exact sum in units of 2^-149, then a single RNE rounding.
    function automatic logic [31:0] ref_add(input logic [31:0] x,
                                            input logic [31:0] y0,
                                            input logic m);
        logic [31:0]  y;
        logic         nx, ny, ix, iy, sg;
        logic [319:0] mx, my, mag, kept, rem, half;
        int           p, sh, bexp, shx, shy;
        y  = {y0[31] ^ m, y0[30:0]};
        nx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        ny = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        ix = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        iy = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        if (nx || ny || (ix && iy && x[31] != y[31]))
            return 32'h7FC00000;
        if (ix) return x;
        if (iy) return y;
        shx = (x[30:23] == 8'd0) ? 0 : int'(x[30:23]) - 1;
        shy = (y[30:23] == 8'd0) ? 0 : int'(y[30:23]) - 1;
        mx  = 320'({(x[30:23] != 8'd0), x[22:0]}) << shx;
        my  = 320'({(y[30:23] != 8'd0), y[22:0]}) << shy;
        if (x[31] == y[31]) begin
            mag = mx + my; sg = x[31];
        end else if (mx >= my) begin
            mag = mx - my; sg = x[31];
        end else begin
            mag = my - mx; sg = y[31];
        end
        if (mag == 320'd0)
            return {x[31] & y[31], 31'd0};
        p = 0;
        for (int i = 0; i < 320; i++)
            if (mag[i]) p = i;
        if (p <= 23)
            return {sg, mag[30:0]};
        sh   = p - 23;
        kept = mag >> sh;
        rem  = mag - (kept << sh);
        half = 320'd1 << (sh - 1);
        if (rem > half || (rem == half && kept[0]))
            kept = kept + 320'd1;
        if (kept[24]) begin
            kept = kept >> 1;
            p++;
        end
        bexp = p - 22;
        if (bexp >= 255)
            return {sg, 8'hFF, 23'd0};
        return {sg, bexp[7:0], kept[22:0]};
    endfunction

    // One transaction: accept, count edges to out_valid, optional stall.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                          input logic im, input bit early, input bit junk,
                          input int hold, output logic [31:0] r,
                          output int lat);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a         = ia;
        bus.b         = ib;
        bus.mode      = im;
        bus.in_valid  = 1'b1;
        bus.out_ready = early;
        @(posedge clk);
        #1;
        bus.in_valid = junk;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.mode     = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        if (lat >= 60)
            chk("out_valid_timeout", 32'(lat), 32'd55);
        r = bus.res;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk("stall_res", bus.res, r);
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                chk("stall_busy", 32'(bus.busy), 32'd1);
            end
            @(negedge clk);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, want;
        int          lat, sel, ea, eb, seen;
        logic [7:0]  ea8, eb8;

        vt[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3};
        vt[1]  = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 6};
        vt[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3};
        vt[3]  = '{32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 29};
        vt[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3};
        vt[5]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2};
        vt[6]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2};
        vt[7]  = '{32'hFF800000, 32'h40A00000, 1'b0, 32'hFF800000, 2};
        vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3};
        vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3};
        vt[10] = '{32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 3};
        vt[11] = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3};
        vt[12] = '{32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 3};
        vt[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2};
        vt[14] = '{32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 2};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode      = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_res", bus.res, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].m, 1'b0, 1'b0, 0, r, lat);
            chk($sformatf("vec%0d_res", i), r, vt[i].res);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
        end

        // Backpressure then a second operation
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b1, 5, r, lat);
        chk("bp_res", r, 32'h40000000);
        chk("bp_lat", 32'(lat), 32'd3);
        run_op(32'h3F800000, 32'h3F400000, 1'b1, 1'b0, 1'b0, 0, r, lat);
        chk("bp2_res", r, 32'h3E800000);
        chk("bp2_lat", 32'(lat), 32'd6);

        // Reset while aligning
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h30800000;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_busy", 32'(bus.busy), 32'd0);
        chk("rr_valid", 32'(bus.out_valid), 32'd0);
        chk("rr_res", bus.res, 32'h0);
        chk("rr_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        chk("rr_no_valid", 32'(seen), 32'd0);
        chk("rr_res_hold", bus.res, 32'h0);
        run_op(32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 0, r, lat);
        chk("rr_after_res", r, 32'h40000000);
        chk("rr_after_lat", 32'(lat), 32'd3);

        // Random operands against the exact model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ra, rb;
            logic        rm;
            sel = $urandom_range(0, 9);
            ea  = $urandom_range(1, 254);
            eb  = ea + $urandom_range(0, 60) - 30;
            if (sel == 1) begin
                ea = 0;
                eb = $urandom_range(0, 2);
            end else if (sel == 2) begin
                ea = $urandom_range(250, 254);
                eb = ea;
            end
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            ea8 = 8'(ea);
            eb8 = 8'(eb);
            ra  = {1'($urandom), ea8, 23'($urandom)};
            rb  = {1'($urandom), eb8, 23'($urandom)};
            if (sel == 0) begin
                ra = $urandom;
                rb = $urandom;
            end
            rm   = 1'($urandom);
            want = ref_add(ra, rb, rm);
            run_op(ra, rb, rm, 1'($urandom), 1'($urandom), 0, r, lat);
            if (r !== want)
                $display("  operands a=%h b=%h mode=%0d", ra, rb, rm);
            chk("rand_res", r, want);
            chk("rand_lat_ok", 32'(lat >= 2 && lat <= 55), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
